tile_pixel_fetch: RTL and testbench

- Raster-side address generator and colour selector for the 20x20 tile layer.
- Sits between the VGA pixel counter and the tile sprite ROMs (ground brick, spine, spine_move, save_point, save_point2, 40x20 arrow), plus an external 32x24 tile-map ROM.
- Tracks tile column/row and in-tile offset incrementally (no dividers) and drives the ROM addresses.
- Aligns the 1-cycle ROM latencies in a pipeline, animates spine/save-point tiles, and emits one 4-bit colour index per pixel.

---
 rtl/tile_pkg.sv | 25 ++
 rtl/tile_pixel_fetch_if.sv | 23 ++
 rtl/tile_raster_tracker.sv | 68 ++++++
 rtl/tile_pixel_fetch.sv | 146 ++++++++++++++
 tb/tb_tile_pixel_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared tile-layer types and constants for the tile pixel fetch pipeline.
package tile_pkg;

  typedef enum logic [3:0] {
    EMPTY   = 4'd0,
    BRICK   = 4'd1,
    SPINE   = 4'd2,
    SAVE    = 4'd3,
    ARROW_L = 4'd4,
    ARROW_R = 4'd5
  } tile_code_t;

  localparam int TILE_W   = 20;
  localparam int MAP_COLS = 32;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
  localparam logic [3:0] GRID_IDX        = 4'hF;

  function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
    return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/tile_pixel_fetch_if.sv
// ROM-side bus of the tile fetch: map/tile/arrow addresses out, 1-cycle ROM data back.
interface tile_pixel_fetch_if;
  logic [9:0]  map_addr;
  logic [3:0]  map_tile;
  logic [12:0] tile_addr;
  logic [12:0] arrow_addr;
  logic [3:0]  brick_idx;
  logic [3:0]  spine_idx;
  logic [3:0]  spine_mv_idx;
  logic [3:0]  save_idx;
  logic [3:0]  save2_idx;
  logic [3:0]  arrow_idx;

  modport master (
    output map_addr, tile_addr, arrow_addr,
    input  map_tile, brick_idx, spine_idx, spine_mv_idx, save_idx, save2_idx, arrow_idx
  );

  modport slave (
    input  map_addr, tile_addr, arrow_addr,
    output map_tile, brick_idx, spine_idx, spine_mv_idx, save_idx, save2_idx, arrow_idx
  );
endinterface

// File: rtl/tile_raster_tracker.sv
// Incremental tile column/row and in-tile offset tracker; registers the map ROM address.
module tile_raster_tracker #(
  parameter int TILE_W   = tile_pkg::TILE_W,
  parameter int MAP_COLS = tile_pkg::MAP_COLS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       pixel_valid,
  output logic [$clog2(TILE_W)-1:0] off_x,
  output logic [$clog2(TILE_W)-1:0] off_y,
  output logic [9:0] map_addr
);
  import tile_pkg::*;

  localparam int OFF_W = $clog2(TILE_W);
  localparam int COL_W = $clog2(MAP_COLS);
  localparam int ROW_W = 10 - COL_W;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(TILE_W - 1);

  logic [COL_W-1:0] col, col_n;
  logic [ROW_W-1:0] row, row_n;
  logic [OFF_W-1:0] off_x_n, off_y_n;

  always_comb begin
    col_n   = col;
    row_n   = row;
    off_x_n = off_x;
    off_y_n = off_y;
    if (DrawX == '0) begin
      col_n   = '0;
      off_x_n = '0;
      if (DrawY == '0) begin
        row_n   = '0;
        off_y_n = '0;
      end else if (off_y == OFF_LAST) begin
        off_y_n = '0;
        row_n   = row + ROW_W'(1);
      end else begin
        off_y_n = off_y + OFF_W'(1);
      end
    end else if (off_x == OFF_LAST) begin
      off_x_n = '0;
      col_n   = col + COL_W'(1);
    end else begin
      off_x_n = off_x + OFF_W'(1);
    end
  end

  // stage 0: tracker state and map address both describe the pixel just accepted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col      <= '0;
      row      <= '0;
      off_x    <= '0;
      off_y    <= '0;
      map_addr <= '0;
    end else if (pixel_valid) begin
      col      <= col_n;
      row      <= row_n;
      off_x    <= off_x_n;
      off_y    <= off_y_n;
      map_addr <= {row_n, col_n};
    end
  end

endmodule

// File: rtl/tile_pixel_fetch.sv
// Tile-layer pixel fetch: tracker, ROM address stage, animated colour select (3-cycle latency).
// Optional grid overlay when TILE_GRID_DEBUG_EN is defined.
module tile_pixel_fetch #(
  parameter int TILE_W      = tile_pkg::TILE_W,
  parameter int MAP_COLS    = tile_pkg::MAP_COLS,
  parameter int ANIM_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       pixel_valid,
  input  logic       frame_start,
  tile_pixel_fetch_if.master rom,
  output logic [3:0] color_idx,
  output logic       out_valid,
  output logic [9:0] out_x,
  output logic [9:0] out_y
);
  import tile_pkg::*;

  localparam int OFF_W  = $clog2(TILE_W);
  localparam int ANIM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

  logic [OFF_W-1:0] off_x_p0, off_y_p0;
  logic [9:0]       map_addr_p0;
  logic             vld_p0, vld_p1, vld_p2;
  logic [9:0]       x_p0, y_p0, x_p1, y_p1, x_p2, y_p2;
  logic             phase_p0, phase_p1, phase_p2;
  logic [12:0]      arrow_base_p1;
  logic [3:0]       tile_p2;
  logic [3:0]       color_n;
  logic [ANIM_W-1:0] anim_cnt;
  logic             anim_phase;
`ifdef TILE_GRID_DEBUG_EN
  logic             grid_p1, grid_p2;
`endif

  tile_raster_tracker #(
    .TILE_W   (TILE_W),
    .MAP_COLS (MAP_COLS)
  ) u_tracker (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pixel_valid (pixel_valid),
    .off_x       (off_x_p0),
    .off_y       (off_y_p0),
    .map_addr    (map_addr_p0)
  );

  assign rom.map_addr = map_addr_p0;

  // map_tile only lands during stage 1, so the ARROW_R right-half select is added after the base register
  assign rom.arrow_addr = arrow_base_p1 +
                          ((vld_p1 && (rom.map_tile == ARROW_R)) ? 13'(TILE_W) : 13'd0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      anim_cnt   <= '0;
      anim_phase <= 1'b0;
    end else if (frame_start) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt   <= '0;
        anim_phase <= ~anim_phase;
      end else begin
        anim_cnt <= anim_cnt + ANIM_W'(1);
      end
    end
  end

  // control and externally visible registers, cleared by reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      out_valid     <= 1'b0;
      rom.tile_addr <= '0;
      arrow_base_p1 <= '0;
      color_idx     <= '0;
      out_x         <= '0;
      out_y         <= '0;
    end else begin
      vld_p0    <= pixel_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      // stage 1: in-tile ROM addresses
      if (vld_p0) begin
        rom.tile_addr <= 13'(off_y_p0) * 13'(TILE_W) + 13'(off_x_p0);
        arrow_base_p1 <= 13'(off_y_p0) * 13'(2 * TILE_W) + 13'(off_x_p0);
      end
      // stage 3: registered colour and coordinates
      if (vld_p2) begin
        color_idx <= color_n;
        out_x     <= x_p2;
        out_y     <= y_p2;
      end
    end
  end

  // data-only pipeline: qualified by the valids, no reset needed
  always_ff @(posedge Clk) begin
    if (pixel_valid) begin
      x_p0     <= DrawX;
      y_p0     <= DrawY;
      phase_p0 <= anim_phase;
    end
    if (vld_p0) begin
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      phase_p1 <= phase_p0;
`ifdef TILE_GRID_DEBUG_EN
      grid_p1  <= (off_x_p0 == '0) || (off_y_p0 == '0);
`endif
    end
    // stage 2: map code and ROM data aligned
    if (vld_p1) begin
      x_p2     <= x_p1;
      y_p2     <= y_p1;
      phase_p2 <= phase_p1;
      tile_p2  <= rom.map_tile;
`ifdef TILE_GRID_DEBUG_EN
      grid_p2  <= grid_p1;
`endif
    end
  end

  always_comb begin
    color_n = TRANSPARENT_IDX;
    case (tile_p2)
      BRICK:            color_n = rom.brick_idx;
      SPINE:            color_n = phase_p2 ? rom.spine_mv_idx : rom.spine_idx;
      SAVE:             color_n = phase_p2 ? rom.save2_idx : rom.save_idx;
      ARROW_L, ARROW_R: color_n = rom.arrow_idx;
      default:          color_n = TRANSPARENT_IDX;
    endcase
`ifdef TILE_GRID_DEBUG_EN
    if (grid_p2) color_n = GRID_IDX;
`endif
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Directed bench for tile_pixel_fetch: vector table plus reset and animation sequences.
module tb_tile_pixel_fetch;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX, DrawY;
  logic       pixel_valid, frame_start;
  logic [3:0] color_idx;
  logic       out_valid;
  logic [9:0] out_x, out_y;
  logic [3:0] map_code;

  int errors = 0;
  int checks = 0;

  tile_pixel_fetch_if rom_bus ();

  tile_pixel_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .rom         (rom_bus),
    .color_idx   (color_idx),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y)
  );

  always #5 Clk = ~Clk;

  // map ROM with 1-cycle latency; content is uniform per test vector
  always @(posedge Clk) rom_bus.map_tile <= map_code;

  typedef struct {
    int         x;
    int         y;
    logic [3:0] code;
    int         map;
    int         tile;
    int         arrow;
    int         color;
    bit         grid;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_color(input vec_t v, input int normal);
`ifdef TILE_GRID_DEBUG_EN
    if (v.grid) return 15;
`endif
    return normal;
  endfunction

  // walk the tracker to (x,y): one DrawX==0 pixel per line, then along the target line
  task automatic goto_pixel(input int x, input int y);
    for (int yy = 0; yy <= y; yy++) begin
      DrawX = 10'd0; DrawY = 10'(yy); pixel_valid = 1'b1;
      tick();
    end
    for (int xx = 1; xx <= x; xx++) begin
      DrawX = 10'(xx); DrawY = 10'(y); pixel_valid = 1'b1;
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int normal_color, input string tag);
    map_code = v.code;
    goto_pixel(v.x, v.y);
    chk({tag, " map_addr"}, 32'(rom_bus.map_addr), 32'(v.map));
    tick();
    chk({tag, " tile_addr"}, 32'(rom_bus.tile_addr), 32'(v.tile));
    chk({tag, " arrow_addr"}, 32'(rom_bus.arrow_addr), 32'(v.arrow));
    tick();
    tick();
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_x"}, 32'(out_x), 32'(v.x));
    chk({tag, " out_y"}, 32'(out_y), 32'(v.y));
    chk({tag, " color_idx"}, 32'(color_idx), 32'(exp_color(v, normal_color)));
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " map_addr"}, 32'(rom_bus.map_addr), 32'd0);
    chk({tag, " tile_addr"}, 32'(rom_bus.tile_addr), 32'd0);
    chk({tag, " arrow_addr"}, 32'(rom_bus.arrow_addr), 32'd0);
    chk({tag, " color_idx"}, 32'(color_idx), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_x"}, 32'(out_x), 32'd0);
    chk({tag, " out_y"}, 32'(out_y), 32'd0);
  endtask

  initial begin
    vec_t sv;
    logic [3:0] held;

    //          x    y    code  map  tile arrow color grid
    vecs[0] = '{45,  63,  4'd1, 98,  65,  125,  7,    1'b0};
    vecs[1] = '{25,  42,  4'd5, 65,  45,  105,  9,    1'b0};
    vecs[2] = '{25,  42,  4'd4, 65,  45,  85,   9,    1'b0};
    vecs[3] = '{0,   0,   4'd0, 0,   0,   0,    0,    1'b1};
    vecs[4] = '{639, 479, 4'd9, 767, 399, 779,  0,    1'b0};
    vecs[5] = '{100, 200, 4'd3, 325, 0,   0,    4,    1'b1};
    vecs[6] = '{20,  100, 4'd1, 161, 0,   0,    7,    1'b1};
    vecs[7] = '{21,  41,  4'd2, 65,  21,  41,   2,    1'b0};

    rom_bus.brick_idx    = 4'd7;
    rom_bus.spine_idx    = 4'd2;
    rom_bus.spine_mv_idx = 4'd3;
    rom_bus.save_idx     = 4'd4;
    rom_bus.save2_idx    = 4'd5;
    rom_bus.arrow_idx    = 4'd9;
    map_code    = 4'd1;
    Reset       = 1'b1;
    DrawX       = '0;
    DrawY       = '0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], vecs[i].color, $sformatf("vec%0d", i));

    // bubble: out_valid drops, colour holds
    held = color_idx;
    tick();
    chk("bubble out_valid", 32'(out_valid), 32'd0);
    chk("bubble color_hold", 32'(color_idx), 32'(held));

    // animation: phase toggles on the 16th frame_start
    sv = vecs[7];
    pulse_frames(15);
    run_vec(sv, 2, "anim15 spine");
    pulse_frames(1);
    run_vec(sv, 3, "anim16 spine");
    sv.code = 4'd3;
    run_vec(sv, 5, "anim16 save");
    sv.code = 4'd2;
    pulse_frames(16);
    run_vec(sv, 2, "anim32 spine");

    // asynchronous reset mid-line, then restart at DrawX==0
    map_code = 4'd1;
    for (int xx = 0; xx < 6; xx++) begin
      DrawX = 10'(xx); DrawY = 10'd0; pixel_valid = 1'b1;
      tick();
    end
    Reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    pixel_valid = 1'b0;
    tick();
    Reset = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    tick();
    tick();
    chk("postreset early out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("postreset out_valid", 32'(out_valid), 32'd1);
    chk("postreset out_x", 32'(out_x), 32'd0);
    chk("postreset out_y", 32'(out_y), 32'd0);
    sv = vecs[3];
    chk("postreset color_idx", 32'(color_idx), 32'(exp_color(sv, 7)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
